lights_out_button_decoder: RTL and testbench

//  Input side of the 3x3 lights-out game: turns the 9 raw push-buttons into
//  one-at-a-time, debounced "cell pressed" events for the game core that owns
//  the field registers. Per button: synchronise, debounce, detect the press

---
 rtl/lights_out_pkg.sv | 18 +
 rtl/lights_out_button_decoder_debounce.sv | 37 +++
 rtl/lights_out_button_decoder.sv | 56 +++++
 tb/tb_lights_out_button_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lights_out_pkg.sv
// lights_out_pkg: shared constants and helpers for the lights-out button input path.
package lights_out_pkg;
   localparam int N_CELLS = 9;
   localparam int CELL_IDX_W = 4;
   localparam logic [CELL_IDX_W-1:0] CELL_IDX_NONE = 4'hF;
   localparam int DEBOUNCE_DEFAULT = 1000;

   function automatic int cnt_w(input int debounce_cycles);
      return $clog2(debounce_cycles + 1);
   endfunction

   // Lowest set cell wins; CELL_IDX_NONE only when nothing is set.
   function automatic logic [CELL_IDX_W-1:0] lowest_idx(input logic [N_CELLS-1:0] v);
      lowest_idx = CELL_IDX_NONE;
      for (int i = N_CELLS - 1; i >= 0; i--)
         if (v[i]) lowest_idx = CELL_IDX_W'(i);
   endfunction
endpackage

// File: rtl/lights_out_button_decoder_debounce.sv
// lights_out_debounce: per-button synchroniser, debounce counter and press-edge pulse.
module lights_out_debounce
   import lights_out_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic btn_raw,
   output logic rise
);
   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   logic [1:0] sync_ff;
   logic stable;
   logic [CW-1:0] cnt;
   logic accept;

   // The change is accepted on the edge where the counter would hit DEBOUNCE_CYCLES.
   assign accept = (sync_ff[1] != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign rise = accept & sync_ff[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_ff <= '0;
         stable <= 1'b0;
         cnt <= '0;
      end else if (ena) begin
         sync_ff <= {sync_ff[0], btn_raw};
         if (sync_ff[1] == stable) cnt <= '0;
         else if (accept) begin
            stable <= sync_ff[1];
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/lights_out_button_decoder.sv
// lights_out_button_decoder: debounced press events for the 3x3 lights-out field,
// queued per cell and delivered lowest-index-first over valid/ready.
module lights_out_button_decoder
   import lights_out_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int N_BTN = N_CELLS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [N_BTN-1:0]      btn_raw,
   output logic                  press_valid,
   input  logic                  press_ready,
   output logic [CELL_IDX_W-1:0] press_idx,
   output logic                  press_overrun,
   output logic                  busy
);
   logic [N_BTN-1:0] rise, pending, clr;
   logic hs;

   genvar i;
   generate
      for (i = 0; i < N_BTN; i++) begin : g_btn
         lights_out_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk),
            .rst_n(rst_n),
            .ena(ena),
            .btn_raw(btn_raw[i]),
            .rise(rise[i])
         );
      end
   endgenerate

   assign hs = press_valid & press_ready;
   assign clr = hs ? {{(N_BTN-1){1'b0}}, 1'b1} << press_idx : '0;
   assign busy = |pending | press_valid;

   // A fresh press beats a same-cycle consume of that cell, so it is never lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         press_valid <= 1'b0;
         press_idx <= '0;
         press_overrun <= 1'b0;
      end else if (ena) begin
         pending <= (pending & ~clr) | rise;
         press_overrun <= |(rise & pending & ~clr);
         if (hs) press_valid <= 1'b0;
         else if (!press_valid && |pending) begin
            press_valid <= 1'b1;
            press_idx <= lowest_idx(pending);
         end
      end
   end
endmodule

// File: tb/tb_lights_out_button_decoder.sv
// tb_lights_out_button_decoder: directed scenarios checked against a sample-history
// model of debounce and an event-queue model of delivery.
module tb_lights_out_button_decoder;
   localparam int D = 4;
   logic clk = 1'b0;
   logic rst_n, ena, press_ready;
   logic [8:0] btn_raw;
   logic press_valid, press_overrun, busy;
   logic [3:0] press_idx;
   int n_tests = 0, n_fail = 0;

   lights_out_button_decoder #(.DEBOUNCE_CYCLES(D), .N_BTN(9)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .btn_raw(btn_raw),
      .press_valid(press_valid),
      .press_ready(press_ready),
      .press_idx(press_idx),
      .press_overrun(press_overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Model: raw samples kept as a history; a level change is accepted once the
   // samples that have reached the synchroniser output for D edges all disagree.
   logic [15:0] hist [9];
   logic [8:0] m_st, m_pend, m_rise, m_clr;
   logic m_valid, m_ovr;
   int m_idx;
   bit model_ok = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < 9; b++) hist[b] = '0;
         m_st = '0;
         m_pend = '0;
         m_valid = 0;
         m_ovr = 0;
         m_idx = 0;
         model_ok = 1;
      end else if (ena && model_ok) begin
         m_rise = '0;
         for (int b = 0; b < 9; b++) begin
            if (m_st[b] ? (hist[b][D:1] == '0) : (&hist[b][D:1])) begin
               m_st[b] = ~m_st[b];
               m_rise[b] = m_st[b];
            end
            hist[b] = {hist[b][14:0], btn_raw[b]};
         end
         m_clr = (m_valid && press_ready) ? 9'(1 << m_idx) : 9'd0;
         m_ovr = |(m_rise & m_pend & ~m_clr);
         if (m_clr != 0) m_valid = 0;
         else if (!m_valid && m_pend != 0) begin
            m_valid = 1;
            for (int c = 8; c >= 0; c--) if (m_pend[c]) m_idx = c;
         end
         m_pend = (m_pend & ~m_clr) | m_rise;
      end
   end

   int acc[$];
   int ovr_cnt = 0;
   bit seen_valid = 0;

   always @(negedge clk) begin
      if (model_ok) begin
         chk("valid", press_valid, m_valid);
         chk("idx", press_idx, m_idx);
         chk("overrun", press_overrun, m_ovr);
         chk("busy", busy, (m_pend != 0) || m_valid);
      end
      if (rst_n && ena && press_valid && press_ready) acc.push_back(int'(press_idx));
      if (rst_n && ena && press_overrun) ovr_cnt++;
      if (press_valid) seen_valid = 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 0;
      ena = 1;
      btn_raw = '0;
      press_ready = 0;
      tick(2);
      chk("rst_valid", press_valid, 0);
      chk("rst_idx", press_idx, 0);
      chk("rst_overrun", press_overrun, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1;
      tick(2);

      // 1: single press on cell 4
      btn_raw[4] = 1;
      press_ready = 1;
      tick(6);
      chk("t1_not_yet", press_valid, 0);
      tick(1);
      chk("t1_valid", press_valid, 1);
      chk("t1_idx", press_idx, 4);
      tick(1);
      chk("t1_dropped", press_valid, 0);
      chk("t1_busy", busy, 0);
      btn_raw[4] = 0;
      tick(10);
      chk("t1_count", acc.size(), 1);
      chk("t1_ev", acc[0], 4);
      acc.delete();

      // 2: glitch shorter than debounce window
      seen_valid = 0;
      btn_raw[0] = 1;
      tick(3);
      btn_raw[0] = 0;
      tick(15);
      chk("t2_seen", seen_valid, 0);
      chk("t2_count", acc.size(), 0);
      chk("t2_busy", busy, 0);

      // 3: simultaneous presses on cells 2 and 7
      press_ready = 0;
      btn_raw[2] = 1;
      btn_raw[7] = 1;
      tick(7);
      chk("t3_valid", press_valid, 1);
      chk("t3_idx", press_idx, 2);
      tick(10);
      chk("t3_hold_valid", press_valid, 1);
      chk("t3_hold_idx", press_idx, 2);
      press_ready = 1;
      tick(1);
      chk("t3_gap", press_valid, 0);
      tick(1);
      chk("t3_second_idx", press_idx, 7);
      tick(1);
      chk("t3_count", acc.size(), 2);
      chk("t3_ev0", acc[0], 2);
      chk("t3_ev1", acc[1], 7);
      btn_raw = '0;
      press_ready = 0;
      tick(10);
      acc.delete();

      // 4: repeated press on a cell already pending
      ovr_cnt = 0;
      btn_raw[1] = 1;
      tick(7);
      chk("t4_idx", press_idx, 1);
      btn_raw[3] = 1;
      tick(8);
      btn_raw[3] = 0;
      tick(8);
      btn_raw[3] = 1;
      tick(8);
      chk("t4_overrun", ovr_cnt, 1);
      press_ready = 1;
      tick(16);
      chk("t4_count", acc.size(), 2);
      chk("t4_ev0", acc[0], 1);
      chk("t4_ev1", acc[1], 3);
      chk("t4_busy", busy, 0);
      btn_raw = '0;
      press_ready = 0;
      tick(10);
      acc.delete();

      // 5: reset while an event is presented
      btn_raw[5] = 1;
      tick(7);
      chk("t5_valid", press_valid, 1);
      chk("t5_idx", press_idx, 5);
      rst_n = 0;
      tick(1);
      chk("t5_rst_valid", press_valid, 0);
      chk("t5_rst_idx", press_idx, 0);
      chk("t5_rst_busy", busy, 0);
      rst_n = 1;
      tick(6);
      chk("t5_not_yet", press_valid, 0);
      tick(1);
      chk("t5_again_valid", press_valid, 1);
      chk("t5_again_idx", press_idx, 5);

      // 6: enable low freezes the handshake
      ena = 0;
      press_ready = 1;
      tick(20);
      chk("t6_frozen_valid", press_valid, 1);
      chk("t6_frozen_idx", press_idx, 5);
      chk("t6_no_hs", acc.size(), 0);
      ena = 1;
      tick(1);
      chk("t6_done_valid", press_valid, 0);
      chk("t6_count", acc.size(), 1);
      chk("t6_ev", acc[0], 5);
      btn_raw = '0;
      tick(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
